// File: rtl/uart_host_if_if.sv
// NIC-side bus of the UART host controller. The host (master) drives the
// write/read strobes and the write word; the NIC (slave) drives its ready,
// valid and received word.
interface uart_host_if_if #(
    parameter int DATA_W = 8
);
    logic              nic_tx_ready;
    logic              nic_rx_valid;
    logic [DATA_W-1:0] nic_rx_data;
    logic              nic_wr;
    logic [DATA_W-1:0] nic_wr_data;
    logic              nic_rd;

    modport master (
        input  nic_tx_ready,
        input  nic_rx_valid,
        input  nic_rx_data,
        output nic_wr,
        output nic_wr_data,
        output nic_rd
    );

    modport slave (
        output nic_tx_ready,
        output nic_rx_valid,
        output nic_rx_data,
        input  nic_wr,
        input  nic_wr_data,
        input  nic_rd
    );
endinterface

// File: rtl/uart_host_if.sv
// Host-side controller between board buttons/switches and the UART NIC.
// A send press issues one flow-controlled write; received words are drained
// into a small circular buffer that the view button steps through.
module uart_host_if #(
    parameter int DATA_W   = 8,
    parameter int RX_DEPTH = 4,
    parameter int CNT_W    = 4,
    localparam int PTR_W   = $clog2(RX_DEPTH),
    localparam int LVL_W   = $clog2(RX_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                send_btn,
    input  logic                view_btn,
    input  logic [DATA_W-1:0]   sw_data,
    uart_host_if_if.master      nic,
    output logic [DATA_W-1:0]   disp_data,
    output logic                disp_valid,
    output logic [CNT_W-1:0]    rx_count,
    output logic [CNT_W-1:0]    tx_count,
    output logic [LVL_W-1:0]    rx_level,
    output logic                rx_overflow
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1'b1);
    localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(RX_DEPTH);

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_WAIT = 2'd1,
        TX_HOLD = 2'd2
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_READ = 2'd1,
        RX_GAP  = 2'd2
    } rx_state_t;

    // Button synchronisers and edge-detect history
    logic [1:0]        send_sync_r;
    logic              send_prev_r;
    logic [1:0]        view_sync_r;
    logic              view_prev_r;
    logic              send_pulse_s;
    logic              view_pulse_s;

    tx_state_t         tx_state_r;
    logic [DATA_W-1:0] wr_data_r;
    logic [CNT_W-1:0]  tx_count_r;

    rx_state_t         rx_state_r;
    logic              nic_rd_r;

    logic [DATA_W-1:0] mem_r [RX_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [LVL_W-1:0]  rx_level_r;
    logic [CNT_W-1:0]  rx_count_r;
    logic              rx_overflow_r;
    logic [DATA_W-1:0] disp_data_r;
    logic              disp_valid_r;

    logic              rx_push_s;
    logic              rx_pop_s;
    logic              rx_accept_s;
    logic              rx_drop_s;

    // Two-flop synchronisers plus one history flop per button for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            send_sync_r <= 2'b00;
            send_prev_r <= 1'b0;
            view_sync_r <= 2'b00;
            view_prev_r <= 1'b0;
        end else begin
            send_sync_r <= {send_sync_r[0], send_btn};
            send_prev_r <= send_sync_r[1];
            view_sync_r <= {view_sync_r[0], view_btn};
            view_prev_r <= view_sync_r[1];
        end
    end

    // Rising-edge pulses and the buffer push/pop/drop decisions
    always_comb begin
        send_pulse_s = send_sync_r[1] & ~send_prev_r;
        view_pulse_s = view_sync_r[1] & ~view_prev_r;
        rx_push_s    = (rx_state_r == RX_READ);
        // A pop on an empty buffer is ignored, so the push still lands.
        if (view_pulse_s && (rx_level_r != LVL_ZERO)) begin
            rx_pop_s = 1'b1;
        end else begin
            rx_pop_s = 1'b0;
        end
        // A simultaneous pop frees a slot in a full buffer.
        if (rx_push_s && ((rx_level_r != LVL_FULL) || rx_pop_s)) begin
            rx_accept_s = 1'b1;
        end else begin
            rx_accept_s = 1'b0;
        end
        rx_drop_s = rx_push_s & ~rx_accept_s;
    end

    // TX FSM: latch the word on a send pulse, write on the first ready cycle,
    // then hold until the button is released so each press writes once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_r <= TX_IDLE;
            wr_data_r  <= {DATA_W{1'b0}};
            tx_count_r <= {CNT_W{1'b0}};
        end else begin
            case (tx_state_r)
                TX_IDLE: begin
                    if (send_pulse_s) begin
                        wr_data_r  <= sw_data;
                        tx_state_r <= TX_WAIT;
                    end
                end
                TX_WAIT: begin
                    if (nic.nic_tx_ready) begin
                        tx_state_r <= TX_HOLD;
                        if (tx_count_r != CNT_MAX) begin
                            tx_count_r <= tx_count_r + CNT_ONE;
                        end
                    end
                end
                TX_HOLD: begin
                    if (!send_sync_r[1]) begin
                        tx_state_r <= TX_IDLE;
                    end
                end
                default: begin
                    tx_state_r <= TX_IDLE;
                end
            endcase
        end
    end

    // RX FSM: IDLE -> READ (one read strobe) -> GAP (NIC drops valid) -> IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_r <= RX_IDLE;
            nic_rd_r   <= 1'b0;
        end else begin
            case (rx_state_r)
                RX_IDLE: begin
                    if (nic.nic_rx_valid) begin
                        rx_state_r <= RX_READ;
                        nic_rd_r   <= 1'b1;
                    end else begin
                        nic_rd_r   <= 1'b0;
                    end
                end
                RX_READ: begin
                    rx_state_r <= RX_GAP;
                    nic_rd_r   <= 1'b0;
                end
                RX_GAP: begin
                    rx_state_r <= RX_IDLE;
                    nic_rd_r   <= 1'b0;
                end
                default: begin
                    rx_state_r <= RX_IDLE;
                    nic_rd_r   <= 1'b0;
                end
            endcase
        end
    end

    // Circular receive buffer, display register, RX counter and overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RX_DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_r      <= {PTR_W{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
            rx_level_r    <= LVL_ZERO;
            rx_count_r    <= {CNT_W{1'b0}};
            rx_overflow_r <= 1'b0;
            disp_data_r   <= {DATA_W{1'b0}};
            disp_valid_r  <= 1'b0;
        end else begin
            if (rx_accept_s) begin
                mem_r[wr_ptr_r] <= nic.nic_rx_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
                if (rx_count_r != CNT_MAX) begin
                    rx_count_r <= rx_count_r + CNT_ONE;
                end
            end
            if (rx_pop_s) begin
                disp_data_r  <= mem_r[rd_ptr_r];
                disp_valid_r <= 1'b1;
                rd_ptr_r     <= rd_ptr_r + PTR_ONE;
            end
            if (rx_drop_s) begin
                rx_overflow_r <= 1'b1;
            end
            case ({rx_accept_s, rx_pop_s})
                2'b10:   rx_level_r <= rx_level_r + LVL_ONE;
                2'b01:   rx_level_r <= rx_level_r - LVL_ONE;
                default: rx_level_r <= rx_level_r;
            endcase
        end
    end

    // The write strobe follows ready combinationally in WAIT so the NIC sees
    // it in exactly the cycle it can accept; everything else is a flop.
    assign nic.nic_wr      = (tx_state_r == TX_WAIT) & nic.nic_tx_ready;
    assign nic.nic_wr_data = wr_data_r;
    assign nic.nic_rd      = nic_rd_r;

    assign disp_data   = disp_data_r;
    assign disp_valid  = disp_valid_r;
    assign rx_count    = rx_count_r;
    assign tx_count    = tx_count_r;
    assign rx_level    = rx_level_r;
    assign rx_overflow = rx_overflow_r;

endmodule

// File: tb/tb_uart_host_if.sv
// Directed bench for uart_host_if: send latency and flow control, RX buffering
// and overflow, coincident push/pop, counter saturation and async reset.
module tb_uart_host_if;

    localparam int DATA_W   = 8;
    localparam int RX_DEPTH = 4;
    localparam int CNT_W    = 4;
    localparam int LVL_W    = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              send_btn;
    logic              view_btn;
    logic [DATA_W-1:0] sw_data;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic [CNT_W-1:0]  rx_count;
    logic [CNT_W-1:0]  tx_count;
    logic [LVL_W-1:0]  rx_level;
    logic              rx_overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    int rd_cnt  = 0;

    uart_host_if_if #(.DATA_W(DATA_W)) nic ();

    uart_host_if #(
        .DATA_W   (DATA_W),
        .RX_DEPTH (RX_DEPTH),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .send_btn    (send_btn),
        .view_btn    (view_btn),
        .sw_data     (sw_data),
        .nic         (nic),
        .disp_data   (disp_data),
        .disp_valid  (disp_valid),
        .rx_count    (rx_count),
        .tx_count    (tx_count),
        .rx_level    (rx_level),
        .rx_overflow (rx_overflow)
    );

    always #5 clk = ~clk;

    // Strobe counters sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (nic.nic_wr === 1'b1) wr_cnt++;
        if (nic.nic_rd === 1'b1) rd_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        send_btn         = 1'b0;
        view_btn         = 1'b0;
        nic.nic_rx_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // NIC model: offer one word, hold it until the read strobe, then drop valid
    task automatic rx_word(input logic [7:0] d);
        logic got;
        got = 1'b0;
        nic.nic_rx_data  = d;
        nic.nic_rx_valid = 1'b1;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (nic.nic_rd === 1'b1) got = 1'b1;
        end
        check_eq("rx_rd_seen", {31'd0, got}, 32'd1);
        tick();
        nic.nic_rx_valid = 1'b0;
        tick();
    endtask

    task automatic view_press();
        view_btn = 1'b1;
        tick();
        view_btn = 1'b0;
        repeat (5) tick();
    endtask

    initial begin
        int          base;
        int          first_c;
        int          n_wr;
        logic [7:0]  wdat;
        logic [7:0]  hold_dat;
        logic [7:0]  exp_words [4];

        rst_n            = 1'b0;
        send_btn         = 1'b0;
        view_btn         = 1'b0;
        sw_data          = 8'h00;
        nic.nic_tx_ready = 1'b0;
        nic.nic_rx_valid = 1'b0;
        nic.nic_rx_data  = 8'h00;

        // ---- Reset and idle ----
        do_reset();
        repeat (20) tick();
        check_eq("rst_disp_data",   {24'd0, disp_data}, 32'h0);
        check_eq("rst_disp_valid",  {31'd0, disp_valid}, 32'h0);
        check_eq("rst_tx_count",    {28'd0, tx_count}, 32'h0);
        check_eq("rst_rx_count",    {28'd0, rx_count}, 32'h0);
        check_eq("rst_rx_level",    {29'd0, rx_level}, 32'h0);
        check_eq("rst_overflow",    {31'd0, rx_overflow}, 32'h0);
        check_eq("rst_wr_data",     {24'd0, nic.nic_wr_data}, 32'h0);
        check_eq("rst_no_strobes",  wr_cnt + rd_cnt, 32'd0);

        // ---- Send 0xA5 with ready high, button held 10 cycles ----
        base             = wr_cnt;
        first_c          = -1;
        n_wr             = 0;
        wdat             = 8'h00;
        sw_data          = 8'hA5;
        nic.nic_tx_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 0) send_btn = 1'b1;
            #1;
            if (nic.nic_wr === 1'b1) begin
                n_wr++;
                if (first_c < 0) begin
                    first_c = c;
                    wdat    = nic.nic_wr_data;
                end
            end
            tick();
        end
        send_btn = 1'b0;
        repeat (5) tick();
        check_eq("tx1_latency",  first_c, 32'd3);
        check_eq("tx1_one_wr",   n_wr, 32'd1);
        check_eq("tx1_mon_wr",   wr_cnt - base, 32'd1);
        check_eq("tx1_data",     {24'd0, wdat}, 32'hA5);
        check_eq("tx1_tx_count", {28'd0, tx_count}, 32'd1);

        // ---- Send 0x3C with ready low; second press in WAIT; ready at c=7 ----
        base             = wr_cnt;
        first_c          = -1;
        n_wr             = 0;
        wdat             = 8'h00;
        hold_dat         = 8'h00;
        nic.nic_tx_ready = 1'b0;
        for (int c = 0; c < 15; c++) begin
            case (c)
                0:       begin sw_data = 8'h3C; send_btn = 1'b1; end
                2:       send_btn = 1'b0;
                4:       begin sw_data = 8'h99; send_btn = 1'b1; end
                6:       send_btn = 1'b0;
                7:       nic.nic_tx_ready = 1'b1;
                default: ;
            endcase
            #1;
            if (c == 5) hold_dat = nic.nic_wr_data;
            if (nic.nic_wr === 1'b1) begin
                n_wr++;
                if (first_c < 0) begin
                    first_c = c;
                    wdat    = nic.nic_wr_data;
                end
            end
            tick();
        end
        repeat (3) tick();
        check_eq("tx2_wait_data",   {24'd0, hold_dat}, 32'h3C);
        check_eq("tx2_first_ready", first_c, 32'd7);
        check_eq("tx2_one_wr",      n_wr, 32'd1);
        check_eq("tx2_mon_wr",      wr_cnt - base, 32'd1);
        check_eq("tx2_data",        {24'd0, wdat}, 32'h3C);
        check_eq("tx2_data_stable", {24'd0, nic.nic_wr_data}, 32'h3C);
        check_eq("tx2_tx_count",    {28'd0, tx_count}, 32'd2);

        // ---- Five received words into a 4-deep buffer, then 5 views ----
        base = rd_cnt;
        rx_word(8'h11);
        rx_word(8'h22);
        rx_word(8'h33);
        rx_word(8'h44);
        rx_word(8'h55);
        check_eq("ovf_rd_pulses", rd_cnt - base, 32'd5);
        check_eq("ovf_level",     {29'd0, rx_level}, 32'd4);
        check_eq("ovf_rx_count",  {28'd0, rx_count}, 32'd4);
        check_eq("ovf_flag",      {31'd0, rx_overflow}, 32'd1);
        exp_words[0] = 8'h11;
        exp_words[1] = 8'h22;
        exp_words[2] = 8'h33;
        exp_words[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            view_press();
            check_eq("view_data",  {24'd0, disp_data}, {24'd0, exp_words[i]});
            check_eq("view_valid", {31'd0, disp_valid}, 32'd1);
        end
        check_eq("view_empty_level", {29'd0, rx_level}, 32'd0);
        view_press();
        check_eq("view_empty_data",  {24'd0, disp_data}, 32'h44);
        check_eq("view_empty_valid", {31'd0, disp_valid}, 32'd1);

        // ---- Full buffer, view pulse coincident with READ of 0x66 ----
        do_reset();
        rx_word(8'hA1);
        rx_word(8'hA2);
        rx_word(8'hA3);
        rx_word(8'hA4);
        check_eq("coin_pre_level", {29'd0, rx_level}, 32'd4);
        base            = rd_cnt;
        view_btn        = 1'b1;
        nic.nic_rx_data = 8'h66;
        tick();
        view_btn         = 1'b0;
        nic.nic_rx_valid = 1'b1;
        tick();
        check_eq("coin_rd_now", {31'd0, nic.nic_rd}, 32'd1);
        tick();
        nic.nic_rx_valid = 1'b0;
        repeat (4) tick();
        check_eq("coin_rd_pulses", rd_cnt - base, 32'd1);
        check_eq("coin_level",     {29'd0, rx_level}, 32'd4);
        check_eq("coin_no_ovf",    {31'd0, rx_overflow}, 32'd0);
        check_eq("coin_rx_count",  {28'd0, rx_count}, 32'd5);
        check_eq("coin_pop0",      {24'd0, disp_data}, 32'hA1);
        exp_words[0] = 8'hA2;
        exp_words[1] = 8'hA3;
        exp_words[2] = 8'hA4;
        exp_words[3] = 8'h66;
        for (int i = 0; i < 4; i++) begin
            view_press();
            check_eq("coin_pop", {24'd0, disp_data}, {24'd0, exp_words[i]});
        end

        // ---- 20 accepted receives: rx_count saturates at 15 ----
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            rx_word(8'(i));
            view_press();
            check_eq("sat_word", {24'd0, disp_data}, i);
        end
        check_eq("sat_rx_count", {28'd0, rx_count}, 32'd15);
        check_eq("sat_no_ovf",   {31'd0, rx_overflow}, 32'd0);
        check_eq("sat_level",    {29'd0, rx_level}, 32'd0);

        // ---- Reset asserted mid-WAIT ----
        nic.nic_tx_ready = 1'b0;
        sw_data          = 8'h77;
        send_btn         = 1'b1;
        repeat (5) tick();
        check_eq("rstw_latched", {24'd0, nic.nic_wr_data}, 32'h77);
        base  = wr_cnt;
        rst_n = 1'b0;
        #1;
        check_eq("rstw_async_rx_count", {28'd0, rx_count}, 32'd0);
        check_eq("rstw_async_wr_data",  {24'd0, nic.nic_wr_data}, 32'h0);
        check_eq("rstw_async_disp",     {31'd0, disp_valid}, 32'd0);
        send_btn         = 1'b0;
        nic.nic_tx_ready = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check_eq("rstw_no_wr",    wr_cnt - base, 32'd0);
        check_eq("rstw_tx_count", {28'd0, tx_count}, 32'd0);
        check_eq("rstw_rx_count", {28'd0, rx_count}, 32'd0);
        check_eq("rstw_level",    {29'd0, rx_level}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_host_if.md
Name: uart_host_if

Overview:
- Parametrised host-side controller between the board user interface (switches/buttons) and the UART NIC.
- Issues single-cycle, flow-controlled write strobes to the NIC from a button press.
- Drains received words from the NIC into a RX_DEPTH-entry buffer that the user steps through with a view button.
- Maintains saturating TX/RX counters and a sticky overflow flag; drives display data for the external Binary_2_7SEG decoder.

Parameters:
- DATA_W, 8, width of each data word.
- RX_DEPTH, 4, receive buffer entries; power of two, ≥2.
- CNT_W, 4, width of the TX and RX counters.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- send_btn  in  1  send button, asynchronous, active-high.
- view_btn  in  1  view button: pop the oldest buffered word to the display; asynchronous, active-high.
- sw_data  in  DATA_W  word to transmit; sampled on the send edge.
- nic_tx_ready  in  1  NIC can accept a write this cycle.
- nic_rx_valid  in  1  NIC holds an unread received word.
- nic_rx_data  in  DATA_W  NIC received word.
- nic_wr  out  1  write strobe, one cycle.
- nic_wr_data  out  DATA_W  word presented with nic_wr.
- nic_rd  out  1  read strobe, one cycle.
- disp_data  out  DATA_W  word to the 7-seg decoder.
- disp_valid  out  1  disp_data holds a popped word.
- rx_count  out  CNT_W  words accepted into the buffer, saturating.
- tx_count  out  CNT_W  words written to the NIC, saturating.
- rx_level  out  log2(RX_DEPTH)+1  buffer occupancy.
- rx_overflow  out  1  sticky: a word was dropped.

Behaviour:
- Single clock, clk. rst_n is asynchronous and active-low; all flops clear immediately on assertion and release synchronously.
- Reset values:
  - all outputs 0;
  - buffer empty;
  - FSMs in IDLE;
  - synchronisers 0.
- Buttons: each passes through a 2-flop synchroniser, then rising-edge detection giving a 1-cycle pulse. No debounce; the board layer supplies clean levels.
- TX FSM:
  - IDLE: on send pulse, latch sw_data into nic_wr_data and go to WAIT.
  - WAIT: when nic_tx_ready=1, assert nic_wr for exactly that cycle and go to HOLD. tx_count increments that cycle unless it is at all-ones.
  - HOLD: stay until the synchronised send_btn is 0, then go to IDLE. One write per press, regardless of hold time.
  - Send pulses outside IDLE are ignored.
  - nic_wr_data stays stable from the latch until the next latch.
  - Latency: press edge to nic_wr is 3 cycles minimum (2 sync + 1), when ready is already high.
- RX FSM:
  - IDLE: if nic_rx_valid=1, go to READ.
  - READ: assert nic_rd for one cycle. In the same cycle, push nic_rx_data into the buffer if not full. Go to GAP.
  - GAP: one dead cycle so the NIC can drop valid, then go to IDLE.
  - Minimum read spacing is 3 cycles.
  - Buffer full in READ: nic_rd still pulses (the NIC is drained), the word is dropped, rx_overflow sets, rx_count is unchanged.
- Buffer: circular, with wrapping read/write pointers and an occupancy counter.
- View pulse:
  - if rx_level>0, pop the oldest word into disp_data and set disp_valid=1;
  - if empty, ignored, and disp_data/disp_valid hold their values.
- Simultaneous push and pop:
  - both take effect and rx_level is unchanged;
  - when full, the simultaneous pop frees space, so the push is accepted (no overflow);
  - when empty, the pop is ignored and the push lands.
- rx_count: increments on each accepted push and saturates at 2^CNT_W-1.
- rx_overflow: cleared only by reset.
- Reset mid-transfer: any pending TX word is discarded and strobes drop immediately. Buffer contents are lost.

Test Plan:
- Reset release, idle inputs 20 cycles -> all outputs 0, rx_level=0, no strobes.
- sw_data=0xA5, nic_tx_ready=1, send_btn held 10 cycles -> exactly one nic_wr pulse with nic_wr_data=0xA5, 3 cycles after the edge; tx_count=1.
- nic_tx_ready=0, press send with 0x3C, ready raised 7 cycles later -> nic_wr in the first ready cycle with 0x3C; a second press during WAIT causes no extra write.
- NIC presents 0x11,0x22,0x33,0x44 then 0x55 (RX_DEPTH=4), no views -> 5 nic_rd pulses, rx_level=4, rx_count=4, rx_overflow=1. Then 4 views show 0x11,0x22,0x33,0x44; a 5th view leaves 0x44 with disp_valid=1.
- Buffer full, view pulse coincident with READ of 0x66 -> rx_level stays 4, rx_overflow stays 0, next pops return in order ending with 0x66.
- 20 accepted receives with CNT_W=4 -> rx_count saturates at 15. rst_n asserted mid-WAIT -> nic_wr never pulses, all counters 0.
